// File: rtl/pc_pkg.sv
// Shared types and helpers for the program counter with return-address stack.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_COUNT,
    PC_JUMP,
    PC_CALL,
    PC_RET
  } pc_op_e;

  // Width needed to hold a stack pointer that counts 0..depth inclusive.
  function automatic int unsigned sp_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses; guards push-when-full and pop-when-empty itself.
module return_stack
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_push,
  input  logic                             i_pop,
  input  logic [ADDR_W-1:0]                i_push_data,
  output logic [ADDR_W-1:0]                o_top,
  output logic [sp_width(STACK_DEPTH)-1:0] o_sp,
  output logic                             o_full,
  output logic                             o_empty
);

  localparam int unsigned SpW  = sp_width(STACK_DEPTH);
  localparam int unsigned IdxW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] r_mem [STACK_DEPTH];
  logic [SpW-1:0]    r_sp;
  logic              w_full;
  logic              w_empty;
  logic              w_do_push;
  logic              w_do_pop;
  logic [IdxW-1:0]   w_wr_idx;
  logic [IdxW-1:0]   w_top_idx;

  assign w_full    = (r_sp == SpW'(STACK_DEPTH));
  assign w_empty   = (r_sp == '0);
  // Pop wins if both are ever requested together.
  assign w_do_pop  = i_pop & ~w_empty;
  assign w_do_push = i_push & ~w_full & ~i_pop;
  assign w_wr_idx  = IdxW'(r_sp);
  assign w_top_idx = IdxW'(r_sp - SpW'(1));

  assign o_top   = w_empty ? '0 : r_mem[w_top_idx];
  assign o_sp    = r_sp;
  assign o_full  = w_full;
  assign o_empty = w_empty;

  // Stack pointer: the only reset state of the LIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp <= '0;
    end else if (w_do_push) begin
      r_sp <= r_sp + SpW'(1);
    end else if (w_do_pop) begin
      r_sp <= r_sp - SpW'(1);
    end
  end

  // Entry storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= i_push_data;
    end
  end

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with count/jump/call/return and a hardware return-address stack.
module pc_call_stack
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned RESET_ADDR  = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_count_en,
  input  logic                             i_jump,
  input  logic                             i_call,
  input  logic                             i_ret,
  input  logic                             i_err_clr,
  input  logic [ADDR_W-1:0]                i_jump_addr,
  output logic [ADDR_W-1:0]                o_addr,
  output logic [sp_width(STACK_DEPTH)-1:0] o_sp,
  output logic                             o_stack_empty,
  output logic                             o_stack_full,
  output logic                             o_stack_ovf,
  output logic                             o_stack_unf,
  output logic                             o_wrap,
  output pc_op_e                           o_last_op
);

  logic [ADDR_W-1:0] r_addr;
  logic              r_ovf;
  logic              r_unf;
  logic              r_wrap;
  pc_op_e            r_last_op;

  pc_op_e            w_op;
  logic [ADDR_W-1:0] w_addr_inc;
  logic [ADDR_W-1:0] w_addr_d;
  logic              w_ovf_d;
  logic              w_unf_d;
  logic              w_wrap_d;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_top;
  logic              w_full;
  logic              w_empty;

  assign w_addr_inc = r_addr + ADDR_W'(1);

  return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_return_stack (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (w_addr_inc),
    .o_top       (w_top),
    .o_sp        (o_sp),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Fixed-priority decode: ret > call > jump > count > hold.
  always_comb begin
    w_op = PC_HOLD;
    if (i_ret)           w_op = PC_RET;
    else if (i_call)     w_op = PC_CALL;
    else if (i_jump)     w_op = PC_JUMP;
    else if (i_count_en) w_op = PC_COUNT;
  end

  // Next-state for addr, stack handshake, wrap pulse and sticky faults.
  always_comb begin
    w_addr_d = r_addr;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    w_wrap_d = 1'b0;
    w_ovf_d  = r_ovf & ~i_err_clr;
    w_unf_d  = r_unf & ~i_err_clr;
    unique case (w_op)
      PC_COUNT: begin
        w_addr_d = w_addr_inc;
        w_wrap_d = &r_addr;
      end
      PC_JUMP: w_addr_d = i_jump_addr;
      PC_CALL: begin
        if (w_full) begin
          w_ovf_d = 1'b1;
        end else begin
          w_push   = 1'b1;
          w_addr_d = i_jump_addr;
        end
      end
      PC_RET: begin
        if (w_empty) begin
          w_unf_d = 1'b1;
        end else begin
          w_pop    = 1'b1;
          w_addr_d = w_top;
        end
      end
      default: ;
    endcase
  end

  // Architectural state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= ADDR_W'(RESET_ADDR);
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_wrap    <= 1'b0;
      r_last_op <= PC_HOLD;
    end else begin
      r_addr    <= w_addr_d;
      r_ovf     <= w_ovf_d;
      r_unf     <= w_unf_d;
      r_wrap    <= w_wrap_d;
      r_last_op <= w_op;
    end
  end

  assign o_addr        = r_addr;
  assign o_stack_empty = w_empty;
  assign o_stack_full  = w_full;
  assign o_stack_ovf   = r_ovf;
  assign o_stack_unf   = r_unf;
  assign o_wrap        = r_wrap;
  assign o_last_op     = r_last_op;

endmodule

// File: tb/tb_pc_call_stack.sv
// Bench for pc_call_stack: queue-based reference model plus directed literal checks.
module tb_pc_call_stack;
  import pc_pkg::*;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           count_en = 1'b0;
  logic           jump = 1'b0;
  logic           call = 1'b0;
  logic           ret = 1'b0;
  logic           err_clr = 1'b0;
  logic [AW-1:0]  jump_addr = '0;
  logic [AW-1:0]  addr;
  logic [2:0]     sp;
  logic           stack_empty;
  logic           stack_full;
  logic           stack_ovf;
  logic           stack_unf;
  logic           wrap;
  pc_op_e         last_op;

  pc_call_stack #(
    .ADDR_W      (AW),
    .STACK_DEPTH (DEPTH),
    .RESET_ADDR  (0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_count_en    (count_en),
    .i_jump        (jump),
    .i_call        (call),
    .i_ret         (ret),
    .i_err_clr     (err_clr),
    .i_jump_addr   (jump_addr),
    .o_addr        (addr),
    .o_sp          (sp),
    .o_stack_empty (stack_empty),
    .o_stack_full  (stack_full),
    .o_stack_ovf   (stack_ovf),
    .o_stack_unf   (stack_unf),
    .o_wrap        (wrap),
    .o_last_op     (last_op)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state.
  bit  m_valid = 0;
  int  m_addr;
  int  m_stack[$];
  bit  m_ovf, m_unf, m_wrap;
  int  m_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_step(input bit r, input bit cnt, input bit j, input bit c,
                            input bit rt, input bit clr, input int ja);
    bit new_ovf, new_unf, new_wrap;
    new_ovf = 0; new_unf = 0; new_wrap = 0;
    if (r) begin
      m_addr = 0; m_stack.delete(); m_ovf = 0; m_unf = 0; m_wrap = 0;
      m_last = int'(PC_HOLD);
      return;
    end
    if (rt) begin
      m_last = int'(PC_RET);
      if (m_stack.size() == 0) new_unf = 1;
      else m_addr = m_stack.pop_back();
    end else if (c) begin
      m_last = int'(PC_CALL);
      if (m_stack.size() == DEPTH) new_ovf = 1;
      else begin
        m_stack.push_back((m_addr + 1) % 16);
        m_addr = ja;
      end
    end else if (j) begin
      m_last = int'(PC_JUMP);
      m_addr = ja;
    end else if (cnt) begin
      m_last = int'(PC_COUNT);
      new_wrap = (m_addr == 15);
      m_addr = (m_addr + 1) % 16;
    end else begin
      m_last = int'(PC_HOLD);
    end
    m_ovf  = new_ovf | (m_ovf & !clr);
    m_unf  = new_unf | (m_unf & !clr);
    m_wrap = new_wrap;
  endtask

  // Drive one cycle at the falling edge, advance the model at the rising edge.
  task automatic cyc(input bit r, input bit cnt, input bit j, input bit c,
                     input bit rt, input bit clr, input int ja);
    rst = r; count_en = cnt; jump = j; call = c; ret = rt; err_clr = clr;
    jump_addr = AW'(ja);
    @(posedge clk);
    model_step(r, cnt, j, c, rt, clr, ja);
    if (r) m_valid = 1;
    @(negedge clk);
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("addr",    32'(addr),        32'(m_addr));
      chk("sp",      32'(sp),          32'(m_stack.size()));
      chk("empty",   32'(stack_empty), 32'(m_stack.size() == 0));
      chk("full",    32'(stack_full),  32'(m_stack.size() == DEPTH));
      chk("ovf",     32'(stack_ovf),   32'(m_ovf));
      chk("unf",     32'(stack_unf),   32'(m_unf));
      chk("wrap",    32'(wrap),        32'(m_wrap));
      chk("last_op", 32'(last_op),     32'(m_last));
    end
  end

  initial begin
    // Garbage ops during reset must be overridden.
    cyc(1, 1, 1, 1, 1, 0, 7);
    chk("lit_rst_addr", 32'(addr), 0);
    chk("lit_rst_sp", 32'(sp), 0);
    chk("lit_rst_op", 32'(last_op), 32'(PC_HOLD));

    // Count through the full range and wrap.
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 0, 0, 0, 0, 0);
      if (i == 14) begin
        chk("lit_cnt15_addr", 32'(addr), 15);
        chk("lit_cnt15_wrap", 32'(wrap), 0);
      end
    end
    chk("lit_wrap_addr", 32'(addr), 0);
    chk("lit_wrap_pulse", 32'(wrap), 1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("lit_wrap_gone", 32'(wrap), 0);

    // Simple call/return from addr 3.
    cyc(0, 0, 1, 0, 0, 0, 3);
    cyc(0, 0, 0, 1, 0, 0, 9);
    chk("lit_call_addr", 32'(addr), 9);
    chk("lit_call_sp", 32'(sp), 1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("lit_ret_addr", 32'(addr), 4);
    chk("lit_ret_empty", 32'(stack_empty), 1);

    // Nested calls to overflow.
    for (int i = 1; i <= 4; i++) cyc(0, 0, 0, 1, 0, 0, i);
    chk("lit_full", 32'(stack_full), 1);
    cyc(0, 0, 0, 1, 0, 0, 5);
    chk("lit_ovf_addr", 32'(addr), 4);
    chk("lit_ovf_sp", 32'(sp), 4);
    chk("lit_ovf_flag", 32'(stack_ovf), 1);
    chk("lit_ovf_op", 32'(last_op), 32'(PC_CALL));
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("lit_ovf_sticky", 32'(stack_ovf), 1);
    // New fault beats a simultaneous clear.
    cyc(0, 0, 0, 1, 0, 1, 8);
    chk("lit_ovf_vs_clr", 32'(stack_ovf), 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("lit_ovf_clr", 32'(stack_ovf), 0);

    // Unwind: stack holds 5,2,3,4 (top last); addr is 5 after the count.
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0, 0);
    chk("lit_unwind_addr", 32'(addr), 5);

    // Underflow, then ret with clear keeps flag, clear alone drops it.
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("lit_unf_flag", 32'(stack_unf), 1);
    chk("lit_unf_addr", 32'(addr), 5);
    cyc(0, 0, 0, 0, 1, 1, 0);
    chk("lit_unf_vs_clr", 32'(stack_unf), 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("lit_unf_clr", 32'(stack_unf), 0);

    // Priority: stack holds 7, everything asserted -> ret wins.
    cyc(0, 0, 1, 0, 0, 0, 6);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 1, 0, 2);
    chk("lit_prio_addr", 32'(addr), 7);
    chk("lit_prio_sp", 32'(sp), 0);
    chk("lit_prio_op", 32'(last_op), 32'(PC_RET));
    cyc(0, 1, 1, 0, 0, 0, 2);
    chk("lit_jump_addr", 32'(addr), 2);

    // Back-to-back call/ret at full rate, including pushed-value wrap.
    cyc(0, 0, 1, 0, 0, 0, 15);
    cyc(0, 0, 0, 1, 0, 0, 10);
    chk("lit_wrap_push_nowrap", 32'(wrap), 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("lit_wrap_push_addr", 32'(addr), 0);
    cyc(0, 0, 0, 1, 0, 0, 11);
    cyc(0, 0, 0, 1, 0, 0, 12);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 13);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);

    // Reset mid-sequence with sp=3 and ovf set.
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 0, i + 3);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("lit_pre_rst_sp", 32'(sp), 3);
    chk("lit_pre_rst_ovf", 32'(stack_ovf), 1);
    cyc(1, 0, 0, 1, 0, 0, 9);
    chk("lit_mid_rst_addr", 32'(addr), 0);
    chk("lit_mid_rst_sp", 32'(sp), 0);
    chk("lit_mid_rst_ovf", 32'(stack_ovf), 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_call_stack.md
Name: pc_call_stack

Overview:
Parametrised program counter with a hardware return-address stack, the next-generation PC for the 8-bit CPU core.
- Supports count, absolute jump, subroutine call and return, all controlled by the control-word decoder.
- Drives the instruction-fetch address and reports stack status/fault flags to the control unit.

Parameters:
ADDR_W, 4, width of program address (and return-address entries)
STACK_DEPTH, 4, number of return-address entries (>=1)
RESET_ADDR, 0, value loaded into addr on reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset rst, synchronous, active-high
count_en  input  1  increment addr
jump  input  1  load addr from jump_addr
call  input  1  push addr+1, load addr from jump_addr
ret  input  1  pop top of stack into addr
err_clr  input  1  clear sticky fault flags
jump_addr  input  ADDR_W  target for jump/call
addr  output  ADDR_W  current program address
sp  output  $clog2(STACK_DEPTH+1)  number of valid stack entries
stack_empty  output  1  sp == 0
stack_full  output  1  sp == STACK_DEPTH
stack_ovf  output  1  sticky: call attempted while full
stack_unf  output  1  sticky: ret attempted while empty
wrap  output  1  one-cycle pulse: previous cycle's count took addr from all-ones to 0
last_op  output  pc_op_e  operation executed on the previous edge

Behaviour:
- Reset (rst=1 at edge) sets addr=RESET_ADDR, sp=0, stack_ovf=0, stack_unf=0, wrap=0, last_op=PC_HOLD. Stack contents are don't-care. Reset overrides any op in flight.
- Per edge, exactly one op is executed. Fixed priority: ret > call > jump > count_en > hold. Lower-priority requests in the same cycle are dropped, not queued.
- PC_COUNT:
  - addr <= addr+1, modulo 2^ADDR_W.
  - wrap=1 on the following cycle only when addr was all-ones; otherwise wrap=0.
- PC_JUMP: addr <= jump_addr. Stack is untouched.
- PC_CALL, not full:
  - stack[sp] <= addr+1 (mod 2^ADDR_W); sp <= sp+1; addr <= jump_addr.
  - The pushed value wraps without setting wrap.
- PC_CALL, full:
  - No push and no jump; addr holds; sp holds.
  - stack_ovf <= 1. last_op records PC_CALL.
- PC_RET, not empty: addr <= stack[sp-1]; sp <= sp-1.
- PC_RET, empty: addr holds; sp holds; stack_unf <= 1.
- Fault flags:
  - err_clr clears both fault flags on the next edge.
  - If a new fault occurs in the same cycle as err_clr, the new fault wins (flag reads 1).
- Outputs are registered or derived only from registered state (stack_empty, stack_full from sp). addr changes exactly one edge after the request (latency 1). No combinational path from inputs to outputs.
- Back-to-back call/ret across consecutive cycles is supported at full rate. The stack read uses the registered sp, never a forwarded value.
- STACK_DEPTH=1 must work: one call fills the stack, a second call faults.

Decomposition:
- Package pc_pkg:
  - typedef enum pc_op_e {PC_HOLD, PC_COUNT, PC_JUMP, PC_CALL, PC_RET}.
  - Function for the sp width.
- Sub-module return_stack (LIFO):
  - Parameters: ADDR_W, STACK_DEPTH.
  - Ports: clk, rst, push, pop, push_data, top, sp, full, empty.
  - Guards push-when-full and pop-when-empty internally.
- pc_call_stack contains the priority decode, addr register, fault flags, wrap and last_op.

Test Plan:
- Reset then 16 cycles of count_en (ADDR_W=4) -> addr steps 0..15 then 0; wrap=1 only on the cycle after 15->0.
- addr=3, call with jump_addr=9 -> addr=9, sp=1, top=4. Then ret -> addr=4, sp=0, stack_empty=1.
- STACK_DEPTH=4: five nested calls -> after the 4th call stack_full=1. The 5th call leaves addr and sp unchanged and sets stack_ovf=1, which stays set until err_clr.
- Empty stack, ret -> addr unchanged, stack_unf=1. ret and err_clr in the same cycle -> stack_unf stays 1.
- ret, call, jump and count_en all asserted with stack holding 7 -> addr=7, sp decremented, last_op=PC_RET. jump+count_en with jump_addr=2 -> addr=2.
- Reset asserted mid-sequence with sp=3 and stack_ovf=1 -> next cycle addr=RESET_ADDR, sp=0, all flags 0.
